// File: rtl/tt_spine_ctrl.sv
// Spine head controller: drives the inward spine bundle (user inputs, design
// select, enable) and returns the selected design's outputs. Every select
// change is bracketed by enable-low guard intervals so the row muxes never see
// a select change while enable is high.
module tt_spine_ctrl #(
  parameter int unsigned N_IO      = 8,
  parameter int unsigned N_O       = 8,
  parameter int unsigned N_I       = 10,
  parameter int unsigned GUARD_CYC = 4,
  parameter int unsigned S_OW      = N_O + 2 * N_IO + 2,
  parameter int unsigned S_IW      = N_I + N_IO + 12,
  parameter int unsigned U_OW      = N_O + 2 * N_IO,
  parameter int unsigned U_IW      = N_I + N_IO
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sel_inc_in,
  input  logic            sel_load,
  input  logic [8:0]      sel_value,
  input  logic            ena_req,
  input  logic [U_IW-1:0] usr_i,
  output logic [U_OW-1:0] usr_o,
  output logic [8:0]      cur_sel,
  output logic            active,
  output logic            busy,
  output logic [S_IW-1:0] spine_iw,
  input  logic [S_OW-1:0] spine_ow
);

  localparam logic [3:0] GuardLd = 4'(GUARD_CYC);

  typedef enum logic [1:0] {StOff, StSettle, StOn, StDrain} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [8:0]      pending_q, pending_d;
  logic [8:0]      cur_sel_q, cur_sel_d;
  logic            sync1_q, sync2_q, inc_prev_q;
  logic [U_IW-1:0] usr_in_q;
  logic [U_OW-1:0] usr_out_q;

  logic            inc_pulse;
  logic            sel_req;
  logic [8:0]      sel_next;
  logic            unused_guard;

  // Guard bits of the outward bundle carry no information.
  assign unused_guard = ^{spine_ow[S_OW-1], spine_ow[0]};

  // Pad synchroniser and rising-edge detector for the increment button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      inc_prev_q <= 1'b0;
    end else begin
      sync1_q    <= sel_inc_in;
      sync2_q    <= sync1_q;
      inc_prev_q <= sync2_q;
    end
  end

  assign inc_pulse = sync2_q & ~inc_prev_q;
  assign sel_req   = sel_load | inc_pulse;
  // Load has priority; a coincident increment is dropped.
  assign sel_next  = sel_load ? sel_value : pending_q + 9'd1;

  // State, counter and select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StOff;
      cnt_q     <= 4'd0;
      pending_q <= 9'd0;
      cur_sel_q <= 9'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  // Guard sequencing: cur_sel may only move while enable is low and settled.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = sel_req ? sel_next : pending_q;
    cur_sel_d = cur_sel_q;
    unique case (state_q)
      StOff: begin
        cur_sel_d = pending_q;
        cnt_d     = 4'd0;
        if (ena_req) begin
          state_d = StSettle;
          cnt_d   = GuardLd;
        end
      end
      StSettle: begin
        cur_sel_d = pending_d;
        cnt_d     = cnt_q - 4'd1;
        if (!ena_req) begin
          state_d = StOff;
          cnt_d   = 4'd0;
        end else if (sel_req) begin
          cnt_d = GuardLd;
        end else if (cnt_q <= 4'd1) begin
          state_d = StOn;
        end
      end
      StOn: begin
        if (sel_req || !ena_req) begin
          state_d = StDrain;
          cnt_d   = GuardLd;
        end
      end
      StDrain: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cur_sel_d = pending_d;
          if (ena_req) begin
            state_d = StSettle;
            cnt_d   = GuardLd;
          end else begin
            state_d = StOff;
            cnt_d   = 4'd0;
          end
        end
      end
      default: begin
        state_d = StOff;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign active = (state_q == StOn);
  assign busy   = (state_q == StSettle) || (state_q == StDrain);

  // One-cycle data registers; loaded only while on so nothing from a
  // previous design survives into the first enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      usr_in_q  <= '0;
      usr_out_q <= '0;
    end else begin
      usr_in_q  <= active ? usr_i : '0;
      usr_out_q <= active ? spine_ow[S_OW-2:1] : '0;
    end
  end

  assign usr_o    = active ? usr_out_q : '0;
  assign cur_sel  = cur_sel_q;
  assign spine_iw = {1'b0, (active ? usr_in_q : {U_IW{1'b0}}), cur_sel_q, active, 1'b0};

endmodule

// File: tb/tb_tt_spine_ctrl.sv
// Bench for tt_spine_ctrl: directed steps for the guard timing, then random
// traffic checked against select/data rules computed from plain arithmetic.
module tb_tt_spine_ctrl;

  localparam int G    = 4;
  localparam int U_IW = 18;
  localparam int U_OW = 24;
  localparam int S_IW = 30;
  localparam int S_OW = 26;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sel_inc_in;
  logic            sel_load;
  logic [8:0]      sel_value;
  logic            ena_req;
  logic [U_IW-1:0] usr_i;
  logic [U_OW-1:0] usr_o;
  logic [8:0]      cur_sel;
  logic            active;
  logic            busy;
  logic [S_IW-1:0] spine_iw;
  logic [S_OW-1:0] spine_ow;

  always #5 clk = ~clk;

  tt_spine_ctrl #(.GUARD_CYC(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel_inc_in (sel_inc_in),
    .sel_load   (sel_load),
    .sel_value  (sel_value),
    .ena_req    (ena_req),
    .usr_i      (usr_i),
    .usr_o      (usr_o),
    .cur_sel    (cur_sel),
    .active     (active),
    .busy       (busy),
    .spine_iw   (spine_iw),
    .spine_ow   (spine_ow)
  );

  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  logic [8:0] pend;
  logic [8:0] pend_prev;
  int         inc_due[$];
  bit         off_mode;
  logic       prev_active;
  logic [8:0] prev_cur_sel;
  int         low_cnt;
  bit         had_on;
  logic [U_OW-1:0] ow_keep;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend = 9'd0;
    pend_prev = 9'd0;
    inc_due.delete();
    prev_active = 1'b0;
    prev_cur_sel = 9'd0;
    low_cnt = 0;
    had_on = 1'b0;
  endtask

  // Rising pad edge driven just after edge cyc reaches the select at edge cyc+3.
  task automatic pad_rise();
    sel_inc_in = 1'b1;
    inc_due.push_back(cyc + 3);
  endtask

  // One clock: update the select model and check the per-cycle rules.
  task automatic step();
    logic            ld;
    logic [8:0]      lv;
    logic [U_IW-1:0] u;
    logic [U_OW-1:0] ow;
    logic            act_b;
    bit              inc;
    ld    = sel_load;
    lv    = sel_value;
    u     = usr_i;
    ow    = spine_ow[U_OW:1];
    act_b = active;
    @(posedge clk);
    cyc++;
    #1;
    inc = 1'b0;
    if (inc_due.size() > 0 && inc_due[0] == cyc) begin
      inc = 1'b1;
      void'(inc_due.pop_front());
    end
    pend_prev = pend;
    if (ld) pend = lv;
    else if (inc) pend = pend + 9'd1;

    check("usr_fwd", 32'(spine_iw[28:11]), 32'((act_b && active) ? u : '0));
    check("usr_ret", 32'(usr_o), 32'((act_b && active) ? ow : '0));
    check("iw_guard", {30'd0, spine_iw[29], spine_iw[0]}, 32'd0);
    check("iw_sel", 32'(spine_iw[10:2]), 32'(cur_sel));
    check("iw_ena", 32'(spine_iw[1]), 32'(active));
    check("busy_active_excl", 32'(busy & active), 32'd0);
    if (active) check("on_sel_is_pending", 32'(cur_sel), 32'(pend));
    if (active && prev_active) check("sel_stable_on", 32'(cur_sel), 32'(prev_cur_sel));
    if (active && !prev_active && had_on) check("guard_gap", 32'(low_cnt >= 2 * G), 32'd1);
    if (off_mode) begin
      check("off_idle", {30'd0, busy, active}, 32'd0);
      check("off_sel_lag", 32'(cur_sel), 32'(pend_prev));
    end
    if (active) begin
      had_on = 1'b1;
      low_cnt = 0;
    end else begin
      low_cnt++;
    end
    prev_active = active;
    prev_cur_sel = cur_sel;
  endtask

  initial begin
    int hold;
    int pad_cnt;
    rst_n = 1'b0;
    sel_inc_in = 1'b0;
    sel_load = 1'b0;
    sel_value = 9'd0;
    ena_req = 1'b0;
    usr_i = '0;
    spine_ow = '0;
    off_mode = 1'b0;
    model_reset();
    #12;
    check("rst_iw", 32'(spine_iw), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_usr_o", 32'(usr_o), 32'd0);
    check("rst_cur_sel", 32'(cur_sel), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    off_mode = 1'b1;

    // Load in OFF: select appears one cycle after the request is taken.
    sel_load = 1'b1;
    sel_value = 9'h025;
    step();
    sel_load = 1'b0;
    check("load_lag", 32'(cur_sel), 32'd0);
    step();
    check("load_0x25", 32'(cur_sel), 32'h025);
    check("load_no_ena", 32'(active), 32'd0);

    // Enable: G busy cycles, then on; usr data one cycle after that.
    off_mode = 1'b0;
    ena_req = 1'b1;
    usr_i = 18'h015A5;
    spine_ow = 26'h2ABCDEF;
    for (int i = 0; i < G; i++) begin
      step();
      check("settle_busy", {30'd0, busy, active}, 32'd2);
    end
    step();
    check("on_active", 32'(active), 32'd1);
    check("first_usr_zero", 32'(spine_iw[28:11]), 32'd0);
    check("first_usr_o_zero", 32'(usr_o), 32'd0);
    step();
    check("usr_0x15a5", 32'(spine_iw[28:11]), 32'h015A5);
    ow_keep = spine_ow[U_OW:1];
    check("usr_o_return", 32'(usr_o), 32'(ow_keep));

    // Select change while on: drain, switch, settle.
    sel_load = 1'b1;
    sel_value = 9'h1FF;
    step();
    sel_load = 1'b0;
    check("drain_drop", 32'(active), 32'd0);
    check("drain_old_sel", 32'(cur_sel), 32'h025);
    for (int i = 1; i <= 2 * G; i++) begin
      step();
      check("switch_sel", 32'(cur_sel), (i < G) ? 32'h025 : 32'h1FF);
      check("switch_active", 32'(active), (i == 2 * G) ? 32'd1 : 32'd0);
    end

    // Pad increments in OFF with wrap.
    ena_req = 1'b0;
    repeat (12) step();
    off_mode = 1'b1;
    repeat (3) begin
      pad_rise();
      step();
      step();
      sel_inc_in = 1'b0;
      repeat (4) step();
    end
    check("inc_wrap", 32'(cur_sel), 32'h002);

    // Load and increment landing on the same edge: load wins.
    pad_rise();
    step();
    step();
    sel_load = 1'b1;
    sel_value = 9'h010;
    step();
    sel_load = 1'b0;
    sel_inc_in = 1'b0;
    step();
    check("load_beats_inc", 32'(cur_sel), 32'h010);
    repeat (3) step();
    check("load_beats_inc_hold", 32'(cur_sel), 32'h010);

    // Requests during DRAIN accumulate into the select taken at exit.
    off_mode = 1'b0;
    ena_req = 1'b1;
    repeat (G + 2) step();
    check("on_again", 32'(active), 32'd1);
    sel_load = 1'b1;
    sel_value = 9'h020;
    step();
    check("drain2_drop", 32'(active), 32'd0);
    sel_value = 9'h030;
    pad_rise();
    step();
    sel_load = 1'b0;
    step();
    step();
    sel_inc_in = 1'b0;
    step();
    check("drain_exit_sel", 32'(cur_sel), 32'h031);
    check("drain_exit_settle", {30'd0, busy, active}, 32'd2);
    repeat (G) step();
    check("on_0x31", 32'(active), 32'd1);

    // Reset while on with traffic.
    repeat (3) begin
      usr_i = U_IW'($urandom);
      spine_ow = S_OW'($urandom);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_iw", 32'(spine_iw), 32'd0);
    check("mid_rst_usr_o", 32'(usr_o), 32'd0);
    check("mid_rst_active", 32'(active), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < G; i++) begin
      step();
      check("post_rst_settle", {30'd0, busy, active}, 32'd2);
    end
    step();
    check("post_rst_on", 32'(active), 32'd1);
    check("post_rst_sel", 32'(cur_sel), 32'd0);

    // Random traffic with enable toggling, loads and pad edges.
    hold = 0;
    pad_cnt = 0;
    for (int n = 0; n < 900; n++) begin
      usr_i = U_IW'($urandom);
      spine_ow = S_OW'($urandom);
      if (hold == 0) begin
        ena_req = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(5, 40);
      end else begin
        hold--;
      end
      sel_load = ($urandom_range(0, 19) == 0);
      sel_value = 9'($urandom);
      if (pad_cnt >= 3 && $urandom_range(0, 7) == 0) begin
        if (sel_inc_in) sel_inc_in = 1'b0;
        else pad_rise();
        pad_cnt = 0;
      end else begin
        pad_cnt++;
      end
      step();
    end

    // Random select activity while off.
    ena_req = 1'b0;
    sel_load = 1'b0;
    sel_inc_in = 1'b0;
    repeat (12) step();
    off_mode = 1'b1;
    pad_cnt = 0;
    for (int n = 0; n < 250; n++) begin
      sel_load = ($urandom_range(0, 5) == 0);
      sel_value = 9'($urandom);
      if (pad_cnt >= 3 && $urandom_range(0, 3) == 0) begin
        if (sel_inc_in) sel_inc_in = 1'b0;
        else pad_rise();
        pad_cnt = 0;
      end else begin
        pad_cnt++;
      end
      step();
    end
    sel_load = 1'b0;
    sel_inc_in = 1'b0;
    repeat (6) step();
    check("final_sel", 32'(cur_sel), 32'(pend));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
